// File: rtl/pc_stack_unit.sv
// rtl/pc_stack_unit.sv - program counter with exception vector and circular return-address stack
//
// Holds PC/OldPC and selects the next PC from the ALU result, PC+INC, the
// jump target or the return-address stack. An exception forces EXC_VEC and
// captures the faulting PC in EPC.
//
// Ports:
//   CLK        clock, all state updates on the rising edge
//   rst        asynchronous active-high reset
//   PCEn       PC write enable
//   PCSrc      next-PC select: 00 PCC, 01 PC+INC, 10 JTarget, 11 RAS pop
//   PCC        ALU-computed target, also the fallback when popping an empty RAS
//   JTarget    jump target
//   Push       push PC+INC onto the RAS (call), qualified by PCEn
//   ExcReq     exception request, overrides PCEn
//   ErrClr     clears the sticky RAS error flags
//   PC         current PC
//   OldPC      PC before the last update
//   EPC        PC captured on exception
//   RasTop     top RAS entry, 0 when empty
//   RasCount   occupied RAS entries
//   RasFull    RasCount == RAS_DEPTH
//   RasEmpty   RasCount == 0
//   RasOvf     sticky: push while full
//   RasUnf     sticky: pop while empty
//   Misaligned combinational, PC[1:0] != 0

module pc_stack_unit #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(511),
  parameter logic [WIDTH-1:0] EXC_VEC   = WIDTH'(32'h00000180),
  parameter logic [WIDTH-1:0] INC       = WIDTH'(4),
  parameter int               RAS_DEPTH = 4
) (
  input  logic                         CLK,
  input  logic                         rst,
  input  logic                         PCEn,
  input  logic [1:0]                   PCSrc,
  input  logic [WIDTH-1:0]             PCC,
  input  logic [WIDTH-1:0]             JTarget,
  input  logic                         Push,
  input  logic                         ExcReq,
  input  logic                         ErrClr,
  output logic [WIDTH-1:0]             PC,
  output logic [WIDTH-1:0]             OldPC,
  output logic [WIDTH-1:0]             EPC,
  output logic [WIDTH-1:0]             RasTop,
  output logic [$clog2(RAS_DEPTH):0]   RasCount,
  output logic                         RasFull,
  output logic                         RasEmpty,
  output logic                         RasOvf,
  output logic                         RasUnf,
  output logic                         Misaligned
);

  localparam int SPW = $clog2(RAS_DEPTH);
  localparam int CW  = SPW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(RAS_DEPTH);

  logic [WIDTH-1:0] ras [RAS_DEPTH];
  logic [SPW-1:0]   sp;

  logic [WIDTH-1:0] pc_inc;
  logic [SPW-1:0]   top_idx;
  logic [WIDTH-1:0] top_val;
  logic             upd;
  logic             pop;
  logic             push;
  logic             nonempty;
  logic             full;
  logic             pop_hit;
  logic             ovf_evt;
  logic             unf_evt;
  logic             ras_we;
  logic [SPW-1:0]   ras_widx;
  logic [WIDTH-1:0] next_pc;

  // Modulo-2^WIDTH increment: the top of the address space wraps silently.
  assign pc_inc   = PC + INC;
  assign top_idx  = sp - SPW'(1);
  assign top_val  = ras[top_idx];

  assign upd      = PCEn & ~ExcReq;
  assign pop      = upd & (PCSrc == 2'b11);
  assign push     = upd & Push;
  assign nonempty = (RasCount != '0);
  assign full     = (RasCount == DEPTH_C);
  assign pop_hit  = pop & nonempty;

  // A push that coincides with a successful pop replaces the top in place,
  // so it can never overflow.
  assign ovf_evt  = push & ~pop & full;
  assign unf_evt  = pop & ~nonempty;

  // Combined pop+push rewrites the entry being popped; otherwise write at sp.
  assign ras_we   = push & ~rst;
  assign ras_widx = pop_hit ? top_idx : sp;

  always_comb begin
    next_pc = PCC;
    case (PCSrc)
      2'b00: next_pc = PCC;
      2'b01: next_pc = pc_inc;
      2'b10: next_pc = JTarget;
      2'b11: next_pc = nonempty ? top_val : PCC;
      default: next_pc = PCC;
    endcase
  end

  // RAS storage needs no reset: entries are only visible through RasCount.
  always_ff @(posedge CLK) begin
    if (ras_we) begin
      ras[ras_widx] <= pc_inc;
    end
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      PC       <= RESET_VEC;
      OldPC    <= RESET_VEC;
      EPC      <= '0;
      sp       <= '0;
      RasCount <= '0;
      RasOvf   <= 1'b0;
      RasUnf   <= 1'b0;
    end else begin
      if (ExcReq) begin
        EPC   <= PC;
        OldPC <= PC;
        PC    <= EXC_VEC;
      end else if (PCEn) begin
        OldPC <= PC;
        PC    <= next_pc;
      end

      // Pointer/count: plain push (including push into an empty stack during
      // an underflowing pop) advances; plain successful pop retreats; a
      // combined successful pop+push leaves both unchanged.
      if (push & ~pop_hit) begin
        sp <= sp + SPW'(1);
        if (!full) begin
          RasCount <= RasCount + CW'(1);
        end
      end else if (pop_hit & ~push) begin
        sp       <= sp - SPW'(1);
        RasCount <= RasCount - CW'(1);
      end

      // A new event in the ErrClr cycle keeps the flag set.
      RasOvf <= (RasOvf & ~ErrClr) | ovf_evt;
      RasUnf <= (RasUnf & ~ErrClr) | unf_evt;
    end
  end

  assign RasTop     = nonempty ? top_val : '0;
  assign RasFull    = full;
  assign RasEmpty   = ~nonempty;
  assign Misaligned = |PC[1:0];

endmodule

// File: tb/tb_pc_stack_unit.sv
// tb/tb_pc_stack_unit.sv - randomized and directed bench for pc_stack_unit against a queue-based model
module tb_pc_stack_unit;
  localparam int W = 32;

  logic          CLK = 1'b0;
  logic          rst;
  logic          PCEn;
  logic [1:0]    PCSrc;
  logic [W-1:0]  PCC;
  logic [W-1:0]  JTarget;
  logic          Push;
  logic          ExcReq;
  logic          ErrClr;
  logic [W-1:0]  PC;
  logic [W-1:0]  OldPC;
  logic [W-1:0]  EPC;
  logic [W-1:0]  RasTop;
  logic [2:0]    RasCount;
  logic          RasFull;
  logic          RasEmpty;
  logic          RasOvf;
  logic          RasUnf;
  logic          Misaligned;

  pc_stack_unit dut (
    .CLK(CLK), .rst(rst), .PCEn(PCEn), .PCSrc(PCSrc), .PCC(PCC),
    .JTarget(JTarget), .Push(Push), .ExcReq(ExcReq), .ErrClr(ErrClr),
    .PC(PC), .OldPC(OldPC), .EPC(EPC), .RasTop(RasTop), .RasCount(RasCount),
    .RasFull(RasFull), .RasEmpty(RasEmpty), .RasOvf(RasOvf), .RasUnf(RasUnf),
    .Misaligned(Misaligned)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;

  logic [31:0] m_pc, m_old, m_epc;
  logic [31:0] m_stk[$];
  logic        m_ovf, m_unf;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 511; m_old = 511; m_epc = 0;
    m_stk.delete();
    m_ovf = 0; m_unf = 0;
  endtask

  task automatic model_edge();
    logic [31:0] inc, nxt;
    logic evo, evu;
    evo = 0; evu = 0;
    if (ExcReq) begin
      m_epc = m_pc; m_old = m_pc; m_pc = 32'h180;
    end else if (PCEn) begin
      inc = m_pc + 32'd4;
      nxt = PCC;
      if (PCSrc == 2'd3) begin
        if (m_stk.size() > 0) begin
          nxt = m_stk[m_stk.size()-1];
          if (Push) m_stk[m_stk.size()-1] = inc;
          else void'(m_stk.pop_back());
        end else begin
          nxt = PCC;
          evu = 1;
          if (Push) m_stk.push_back(inc);
        end
      end else begin
        if (PCSrc == 2'd1) nxt = inc;
        else if (PCSrc == 2'd2) nxt = JTarget;
        if (Push) begin
          if (m_stk.size() == 4) begin
            void'(m_stk.pop_front());
            evo = 1;
          end
          m_stk.push_back(inc);
        end
      end
      m_old = m_pc;
      m_pc = nxt;
    end
    m_ovf = (m_ovf && !ErrClr) || evo;
    m_unf = (m_unf && !ErrClr) || evu;
  endtask

  task automatic compare_all();
    int n;
    n = m_stk.size();
    chk("PC", PC, m_pc);
    chk("OldPC", OldPC, m_old);
    chk("EPC", EPC, m_epc);
    chk("RasTop", RasTop, (n > 0) ? m_stk[n-1] : 32'd0);
    chk("RasCount", 32'(RasCount), 32'(n));
    chk("RasFull", 32'(RasFull), 32'(n == 4));
    chk("RasEmpty", 32'(RasEmpty), 32'(n == 0));
    chk("RasOvf", 32'(RasOvf), 32'(m_ovf));
    chk("RasUnf", 32'(RasUnf), 32'(m_unf));
    chk("Misaligned", 32'(Misaligned), 32'((m_pc % 4) != 0));
  endtask

  task automatic step();
    @(posedge CLK);
    if (rst) model_reset();
    else model_edge();
    @(negedge CLK);
    compare_all();
  endtask

  task automatic drive(input logic en, input logic [1:0] src, input logic [31:0] pcc,
                       input logic [31:0] jt, input logic psh, input logic exc, input logic clr);
    PCEn = en; PCSrc = src; PCC = pcc; JTarget = jt; Push = psh; ExcReq = exc; ErrClr = clr;
  endtask

  task automatic set_pc(input logic [31:0] v);
    drive(1, 2'd0, v, 0, 0, 0, 0);
    step();
  endtask

  initial begin
    logic [31:0] pops [4];
    pops[0] = 32'h54; pops[1] = 32'h44; pops[2] = 32'h34; pops[3] = 32'h24;

    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    model_reset();
    repeat (2) @(negedge CLK);
    compare_all();
    chk("rst_PC", PC, 32'd511);
    chk("rst_OldPC", OldPC, 32'd511);
    chk("rst_Empty", 32'(RasEmpty), 32'd1);
    chk("rst_Misaligned", 32'(Misaligned), 32'd1);
    rst = 1'b0;

    // Sequential increment and hold
    set_pc(32'h100);
    drive(1, 2'd1, 0, 0, 0, 0, 0);
    step(); chk("seq1_PC", PC, 32'h104); chk("seq1_Old", OldPC, 32'h100);
    step(); chk("seq2_PC", PC, 32'h108);
    step(); chk("seq3_PC", PC, 32'h10C); chk("seq3_Old", OldPC, 32'h108);
    drive(0, 2'd1, 0, 0, 0, 0, 0);
    step(); chk("hold_PC", PC, 32'h10C);

    // Call and return
    set_pc(32'h200);
    drive(1, 2'd2, 0, 32'h400, 1, 0, 0);
    step(); chk("call_PC", PC, 32'h400); chk("call_top", RasTop, 32'h204);
    chk("call_cnt", 32'(RasCount), 32'd1);
    drive(1, 2'd3, 0, 0, 0, 0, 0);
    step(); chk("ret_PC", PC, 32'h204); chk("ret_empty", 32'(RasEmpty), 32'd1);

    // Overflow, pops, underflow, clear
    set_pc(32'h10);
    for (int i = 1; i <= 5; i++) begin
      drive(1, 2'd0, 32'((i + 1) * 16), 0, 1, 0, 0);
      step();
    end
    chk("ovf_cnt", 32'(RasCount), 32'd4);
    chk("ovf_flag", 32'(RasOvf), 32'd1);
    for (int i = 0; i < 4; i++) begin
      drive(1, 2'd3, 0, 0, 0, 0, 0);
      step(); chk("pop_PC", PC, pops[i]);
    end
    drive(1, 2'd3, 32'h999, 0, 0, 0, 0);
    step(); chk("unf_PC", PC, 32'h999); chk("unf_flag", 32'(RasUnf), 32'd1);
    drive(0, 2'd0, 0, 0, 0, 0, 1);
    step(); chk("clr_ovf", 32'(RasOvf), 32'd0); chk("clr_unf", 32'(RasUnf), 32'd0);

    // Exception overrides PCEn/pop/push
    set_pc(32'h40);
    drive(1, 2'd0, 32'h300, 0, 1, 0, 0);
    step();
    drive(1, 2'd3, 0, 0, 1, 1, 0);
    step(); chk("exc_PC", PC, 32'h180); chk("exc_EPC", EPC, 32'h300);
    chk("exc_cnt", 32'(RasCount), 32'd1); chk("exc_top", RasTop, 32'h44);

    // Wrap and combined pop+push
    set_pc(32'hFFFFFFFC);
    drive(1, 2'd1, 0, 0, 0, 0, 0);
    step(); chk("wrap_PC", PC, 32'h0); chk("wrap_ovf", 32'(RasOvf), 32'd0);
    set_pc(32'h80);
    drive(1, 2'd3, 0, 0, 1, 0, 0);
    step(); chk("pp_PC", PC, 32'h44); chk("pp_top", RasTop, 32'h84);
    chk("pp_cnt", 32'(RasCount), 32'd1);

    // Asynchronous reset mid-cycle
    drive(0, 0, 0, 0, 0, 0, 0);
    @(posedge CLK);
    model_edge();
    #2 rst = 1'b1;
    #1;
    chk("arst_PC", PC, 32'd511);
    chk("arst_Old", OldPC, 32'd511);
    chk("arst_cnt", 32'(RasCount), 32'd0);
    chk("arst_ovf", 32'(RasOvf), 32'd0);
    model_reset();
    @(negedge CLK);
    compare_all();
    rst = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] p, j;
      p = $urandom;
      j = $urandom;
      if ($urandom_range(0, 3) != 0) p[1:0] = 2'b00;
      if ($urandom_range(0, 15) == 0) p = 32'hFFFFFFF0 | ($urandom & 32'hC);
      drive($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), p, j,
            $urandom_range(0, 2) == 0, $urandom_range(0, 19) == 0,
            $urandom_range(0, 9) == 0);
      rst = ($urandom_range(0, 199) == 0);
      step();
      rst = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
